step_sequencer: RTL and testbench
=================================

Name: step_sequencer

Overview:
Synthesizable, parametrised successor of the bench-only Run/Continue stimulus used for the SLC-3 top level. On a start request it waits a programmable delay and emits one Run pulse. It then emits a programmed number of Continue pulses separated by a programmable gap. Optionally each Continue is gated on the CPU reporting a pause. Sits between board buttons/host control and slc3 Run/Continue inputs, and is reused by benches as a self-checking driver.

Parameters:
CNT_W, 16, width of step_count, gap, steps_done
DLY_W, 8, width of run_delay
PULSE_W, 1, width in cycles of every Run/Continue pulse (>=1)
WAIT_PAUSE, 1, 1 = Continue also requires cpu_paused high; 0 = purely timed

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high; clears all state
start  input  1  level; accepted only in IDLE or DONE
abort  input  1  synchronous; returns to IDLE from any state
run_delay  input  DLY_W  cycles from start acceptance to Run rise; latched at accept
step_count  input  CNT_W  number of Continue pulses; latched at accept
gap  input  CNT_W  low cycles between pulses, min 1 enforced (0 treated as 1); latched at accept
cpu_paused  input  1  CPU pause/halt indicator (used when WAIT_PAUSE=1)
Run  output  1  registered Run pulse to CPU
Continue  output  1  registered Continue pulse to CPU
busy  output  1  high from accept until DONE/IDLE
done  output  1  level; high in DONE until next accept or abort
steps_done  output  CNT_W  Continue pulses issued so far this sequence
timeout  output  1  only with STEP_SEQ_TIMEOUT_EN; else tied 0

Interface: one clock; reset is asynchronous and active-high (Clk, Reset).

Behaviour:
- Reset (async, any time incl. mid-pulse): state IDLE; Run, Continue, busy, done, timeout = 0; steps_done = 0; latches cleared. Outputs drop without waiting for a clock edge.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, DELAY, RUN_P, GAP, ARM, CONT_P, DONE.
- IDLE/DONE: start=1 at edge k -> latch inputs, steps_done=0, done=0, busy=1, go to DELAY. In DONE with start=0, hold.
- DELAY: counts run_delay cycles. run_delay=0 -> Run high from edge k+1. Otherwise Run rises at edge k+1+run_delay.
- RUN_P: Run high exactly PULSE_W cycles, then GAP.
- GAP: outputs low for max(gap,1) cycles. Then: if steps_done==step_count -> DONE, else ARM.
- ARM: with WAIT_PAUSE=0, passes through with zero extra cycles (same edge goes to CONT_P). With WAIT_PAUSE=1, waits until cpu_paused=1 at a clock edge, then CONT_P.
- CONT_P: Continue high PULSE_W cycles. steps_done increments on the edge Continue rises. Then GAP.
- step_count=0: Run pulse, one gap, DONE; no Continue.
- DONE: busy=0, done=1.
- start while busy: ignored, no effect on latched values.
- abort=1 at any edge (priority over start and all transitions): IDLE, Run/Continue low next edge, busy=0, done=0, steps_done holds its value.
- steps_done saturates at step_count and never wraps. step_count = 2^CNT_W-1 is legal.
- Run and Continue are never high in the same cycle.

Optional Feature:
STEP_SEQ_TIMEOUT_EN
- Defined: ARM has a watchdog of TIMEOUT_CYC cycles (localparam 1024). Expiry -> timeout=1, go to DONE, done=1. timeout clears on next accept, abort or Reset. Only meaningful with WAIT_PAUSE=1.
- Undefined: ARM waits forever; timeout port tied 0.

Decomposition:
- Package step_seq_pkg: state enum seq_state_t, localparam TIMEOUT_CYC, helper function clamp_gap (gap==0 -> 1).
- One sub-module pulse_timer: loadable down-counter with a zero flag. Shared by DELAY, pulse-width and gap timing. Instantiated once; counter width is max(CNT_W, DLY_W).

Test Plan:
- Reset held 2 cycles, release, no start -> Run=Continue=busy=done=0, steps_done=0 for 50 cycles.
- WAIT_PAUSE=0, run_delay=2, step_count=3, gap=10, start 1 cycle at edge k -> Run high at k+3 only. Continue high at k+14, k+25, k+36. done rises at k+47. steps_done=3.
- WAIT_PAUSE=1, step_count=2, cpu_paused low 30 cycles after gap then high -> first Continue on the cycle after cpu_paused seen, not before. Second Continue likewise.
- Abort during the 2nd gap of a step_count=5 sequence -> IDLE next edge, busy=0, done=0, steps_done=2. A new start with step_count=1 then completes normally with steps_done=1.
- Async Reset asserted mid-Continue pulse (between edges) -> Continue drops immediately. After release the block is in IDLE; start while busy is also confirmed ignored.
- With STEP_SEQ_TIMEOUT_EN and cpu_paused stuck 0 -> timeout=1 and done=1 exactly 1024 cycles after entering ARM. Without the macro -> busy stays 1 and timeout=0.

Source files
------------

// File: rtl/step_seq_pkg.sv
// Shared types and helpers for the step_sequencer Run/Continue driver.
// Holds the sequencer state encoding, the ARM watchdog length and small helpers.
package step_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        RUN_P,
        GAP,
        ARM,
        CONT_P,
        DONE
    } seq_state_t;

    localparam int TIMEOUT_CYC = 1024;

    // A zero gap would let two pulses merge, so it is stretched to one cycle.
    function automatic int unsigned clamp_gap(input int unsigned g);
        return (g == 0) ? 32'd1 : g;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/step_sequencer_pulse_timer.sv
// Loadable down-counter with a zero flag; times the start delay, pulse widths and gaps.
// A load takes priority over a decrement, and the count parks at zero.
module pulse_timer #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/step_sequencer.sv
// Programmable Run/Continue pulse sequencer for the SLC-3 Run and Continue inputs.
// Define STEP_SEQ_TIMEOUT_EN to add a watchdog on the ARM wait and drive the timeout port.
module step_sequencer #(
    parameter int CNT_W      = 16,
    parameter int DLY_W      = 8,
    parameter int PULSE_W    = 1,
    parameter int WAIT_PAUSE = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             abort,
    input  logic [DLY_W-1:0] run_delay,
    input  logic [CNT_W-1:0] step_count,
    input  logic [CNT_W-1:0] gap,
    input  logic             cpu_paused,
    output logic             Run,
    output logic             Continue,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_done,
    output logic             timeout
);

    import step_seq_pkg::*;

`ifdef STEP_SEQ_TIMEOUT_EN
    localparam int TMO_BITS = $clog2(TIMEOUT_CYC);
`else
    localparam int TMO_BITS = 1;
`endif
    localparam int PW_BITS = max_int($clog2(PULSE_W), 1);
    localparam int TMR_W   = max_int(max_int(CNT_W, DLY_W), max_int(TMO_BITS, PW_BITS));
    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_W - 1);

    seq_state_t       state_q, state_nxt;
    logic             run_q, run_nxt;
    logic             cont_q, cont_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic [CNT_W-1:0] steps_q, steps_nxt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] gap_q;
    logic             accept;
    logic             fire_cont;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_dec;
    logic             tmr_zero;
`ifdef STEP_SEQ_TIMEOUT_EN
    logic             tmo_q, tmo_nxt;
`endif

    pulse_timer #(
        .W (TMR_W)
    ) u_timer (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // NOTE: every signal written here gets a default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state_q;
        run_nxt   = run_q;
        cont_nxt  = cont_q;
        busy_nxt  = busy_q;
        done_nxt  = done_q;
        steps_nxt = steps_q;
        accept    = 1'b0;
        fire_cont = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;
`ifdef STEP_SEQ_TIMEOUT_EN
        tmo_nxt   = tmo_q;
`endif

        if (abort) begin
            state_nxt = IDLE;
            run_nxt   = 1'b0;
            cont_nxt  = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
`ifdef STEP_SEQ_TIMEOUT_EN
            tmo_nxt   = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        accept    = 1'b1;
                        state_nxt = DELAY;
                        busy_nxt  = 1'b1;
                        done_nxt  = 1'b0;
                        steps_nxt = '0;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(run_delay);
`ifdef STEP_SEQ_TIMEOUT_EN
                        tmo_nxt   = 1'b0;
`endif
                    end
                end
                DELAY: begin
                    if (tmr_zero) begin
                        state_nxt = RUN_P;
                        run_nxt   = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = PULSE_LOAD;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                RUN_P: begin
                    if (tmr_zero) begin
                        state_nxt = GAP;
                        run_nxt   = 1'b0;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(gap_q - CNT_W'(1));
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                GAP: begin
                    if (!tmr_zero) begin
                        tmr_dec = 1'b1;
                    end else if (steps_q == count_q) begin
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else if (WAIT_PAUSE == 0) begin
                        fire_cont = 1'b1;
                    end else begin
                        state_nxt = ARM;
`ifdef STEP_SEQ_TIMEOUT_EN
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(TIMEOUT_CYC - 1);
`endif
                    end
                end
                ARM: begin
                    if (cpu_paused || (WAIT_PAUSE == 0)) begin
                        fire_cont = 1'b1;
                    end
`ifdef STEP_SEQ_TIMEOUT_EN
                    else if (tmr_zero) begin
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        tmo_nxt   = 1'b1;
                    end else begin
                        tmr_dec = 1'b1;
                    end
`endif
                end
                CONT_P: begin
                    if (tmr_zero) begin
                        state_nxt = GAP;
                        cont_nxt  = 1'b0;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(gap_q - CNT_W'(1));
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    run_nxt   = 1'b0;
                    cont_nxt  = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b0;
                end
            endcase

            // Continue only ever fires while steps_q < count_q, so the count cannot wrap.
            if (fire_cont) begin
                state_nxt = CONT_P;
                cont_nxt  = 1'b1;
                steps_nxt = steps_q + CNT_W'(1);
                tmr_load  = 1'b1;
                tmr_val   = PULSE_LOAD;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            cont_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            steps_q <= '0;
            count_q <= '0;
            gap_q   <= '0;
`ifdef STEP_SEQ_TIMEOUT_EN
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_nxt;
            run_q   <= run_nxt;
            cont_q  <= cont_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            steps_q <= steps_nxt;
`ifdef STEP_SEQ_TIMEOUT_EN
            tmo_q   <= tmo_nxt;
`endif
            if (accept) begin
                count_q <= step_count;
                gap_q   <= CNT_W'(clamp_gap(32'(gap)));
            end
        end
    end

    assign Run        = run_q;
    assign Continue   = cont_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign steps_done = steps_q;
`ifdef STEP_SEQ_TIMEOUT_EN
    assign timeout    = tmo_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: a timed (dut0) and a pause-gated (dut1) instance
// checked every cycle against an event-time model, plus hand-computed pulse timings.
module tb_step_sequencer;

    import step_seq_pkg::*;

    localparam int CNT_W = 16;
    localparam int DLY_W = 8;
    localparam int PW    = 1;
    localparam int WP [2] = '{0, 1};
    localparam int SIG_RUN  = 0;
    localparam int SIG_CONT = 1;
    localparam int SIG_DONE = 2;
    localparam int SIG_TMO  = 3;

    logic clk   = 1'b0;
    logic Reset = 1'b0;
    logic             start_s  [2];
    logic             abort_s  [2];
    logic             paused_s [2];
    logic [DLY_W-1:0] dly_s    [2];
    logic [CNT_W-1:0] cnt_s    [2];
    logic [CNT_W-1:0] gap_s    [2];
    logic             run_o    [2];
    logic             cont_o   [2];
    logic             busy_o   [2];
    logic             done_o   [2];
    logic             tmo_o    [2];
    logic [CNT_W-1:0] steps_o  [2];

    int vectors = 0;
    int misses  = 0;
    int cyc     = 0;
    bit cmp_en  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    step_sequencer #(.CNT_W(CNT_W), .DLY_W(DLY_W), .PULSE_W(PW), .WAIT_PAUSE(0)) dut0 (
        .Clk(clk), .Reset(Reset), .start(start_s[0]), .abort(abort_s[0]),
        .run_delay(dly_s[0]), .step_count(cnt_s[0]), .gap(gap_s[0]), .cpu_paused(paused_s[0]),
        .Run(run_o[0]), .Continue(cont_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .steps_done(steps_o[0]), .timeout(tmo_o[0])
    );

    step_sequencer #(.CNT_W(CNT_W), .DLY_W(DLY_W), .PULSE_W(PW), .WAIT_PAUSE(1)) dut1 (
        .Clk(clk), .Reset(Reset), .start(start_s[1]), .abort(abort_s[1]),
        .run_delay(dly_s[1]), .step_count(cnt_s[1]), .gap(gap_s[1]), .cpu_paused(paused_s[1]),
        .Run(run_o[1]), .Continue(cont_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .steps_done(steps_o[1]), .timeout(tmo_o[1])
    );

    // Model: each sequence is a list of event times (Run rise, next gap end, Continue rise).
    bit act [2], armed [2];
    bit m_run [2], m_cont [2], m_busy [2], m_done [2], m_tmo [2];
    int m_steps [2], n_tot [2], g_m [2];
    int t_run [2], t_cont [2], t_evt [2], t_arm [2];

    always @(posedge clk or posedge Reset) begin : model
        int e;
        bit fire;
        if (Reset) begin
            for (int i = 0; i < 2; i++) begin
                act[i] = 0; armed[i] = 0; m_run[i] = 0; m_cont[i] = 0;
                m_busy[i] = 0; m_done[i] = 0; m_tmo[i] = 0; m_steps[i] = 0;
                t_run[i] = -100; t_cont[i] = -100; t_evt[i] = -100; t_arm[i] = 0;
            end
        end else begin
            e = cyc + 1;
            for (int i = 0; i < 2; i++) begin
                fire = 0;
                if (abort_s[i]) begin
                    act[i] = 0; armed[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_tmo[i] = 0;
                    t_run[i] = -100; t_cont[i] = -100;
                end else if (!act[i]) begin
                    if (start_s[i]) begin
                        act[i] = 1; armed[i] = 0; m_busy[i] = 1; m_done[i] = 0; m_tmo[i] = 0;
                        m_steps[i] = 0;
                        n_tot[i] = int'(cnt_s[i]);
                        g_m[i] = (gap_s[i] == 0) ? 1 : int'(gap_s[i]);
                        t_run[i] = e + 1 + int'(dly_s[i]);
                        t_cont[i] = -100;
                        t_evt[i] = t_run[i] + PW + g_m[i];
                    end
                end else if (armed[i]) begin
                    if (paused_s[i]) begin
                        armed[i] = 0; fire = 1;
                    end
`ifdef STEP_SEQ_TIMEOUT_EN
                    else if (e - t_arm[i] >= TIMEOUT_CYC) begin
                        armed[i] = 0; act[i] = 0; m_busy[i] = 0; m_done[i] = 1; m_tmo[i] = 1;
                    end
`endif
                end else if (e == t_evt[i]) begin
                    if (m_steps[i] == n_tot[i]) begin
                        act[i] = 0; m_busy[i] = 0; m_done[i] = 1;
                    end else if (WP[i] == 0) begin
                        fire = 1;
                    end else begin
                        armed[i] = 1; t_arm[i] = e;
                    end
                end
                if (fire) begin
                    m_steps[i] = m_steps[i] + 1;
                    t_cont[i] = e;
                    t_evt[i] = e + PW + g_m[i];
                end
                m_run[i]  = (e >= t_run[i])  && (e < t_run[i] + PW);
                m_cont[i] = (e >= t_cont[i]) && (e < t_cont[i] + PW);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !Reset) begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if ({run_o[i], cont_o[i], busy_o[i], done_o[i], tmo_o[i], steps_o[i]} !==
                    {m_run[i], m_cont[i], m_busy[i], m_done[i], m_tmo[i], CNT_W'(m_steps[i])}) begin
                    misses++;
                    $display("FAIL cycle%0d dut%0d: got run=%b cont=%b busy=%b done=%b tmo=%b steps=%0d, expected run=%b cont=%b busy=%b done=%b tmo=%b steps=%0d",
                             cyc, i, run_o[i], cont_o[i], busy_o[i], done_o[i], tmo_o[i], steps_o[i],
                             m_run[i], m_cont[i], m_busy[i], m_done[i], m_tmo[i], m_steps[i]);
                end
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            misses++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic sig(input int i, input int w);
        case (w)
            SIG_RUN:  return run_o[i];
            SIG_CONT: return cont_o[i];
            SIG_DONE: return done_o[i];
            default:  return tmo_o[i];
        endcase
    endfunction

    // Returns the edge number at which the selected output rose, or -1 after the budget.
    task automatic wait_rise(input int i, input int w, input int budget, input string name,
                             output int at);
        logic prev;
        prev = sig(i, w);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (sig(i, w) && !prev) begin
                at = cyc;
                break;
            end
            prev = sig(i, w);
        end
        if (at < 0) begin
            vectors++;
            misses++;
            $display("FAIL %s: no rise within %0d cycles, expected one", name, budget);
        end
    endtask

    task automatic pulse_start(input int i, input int d, input int n, input int g, output int k);
        @(negedge clk);
        dly_s[i] = DLY_W'(d);
        cnt_s[i] = CNT_W'(n);
        gap_s[i] = CNT_W'(g);
        start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
        k = cyc;
    endtask

    initial begin
        int k, k2, at;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 0; abort_s[i] = 0; paused_s[i] = 0;
            dly_s[i] = '0; cnt_s[i] = '0; gap_s[i] = '0;
        end
        #1 Reset = 1'b1;
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        cmp_en = 1;

        // Idle after reset.
        repeat (50) @(negedge clk);
        check("idle_run", int'(run_o[0]), 0);
        check("idle_cont", int'(cont_o[0]), 0);
        check("idle_busy", int'(busy_o[0]), 0);
        check("idle_done", int'(done_o[0]), 0);
        check("idle_steps", int'(steps_o[0]), 0);

        // Zero Continue count: Run, one gap, DONE.
        pulse_start(0, 0, 0, 3, k);
        wait_rise(0, SIG_DONE, 20, "zero_cnt_done", at);
        check("zero_cnt_done_at", at, k + 5);
        check("zero_cnt_steps", int'(steps_o[0]), 0);

        // Purely timed sequence.
        pulse_start(0, 2, 3, 10, k);
        wait_rise(0, SIG_RUN, 20, "timed_run", at);
        check("timed_run_at", at, k + 3);
        wait_rise(0, SIG_CONT, 30, "timed_cont1", at);
        check("timed_cont1_at", at, k + 14);
        wait_rise(0, SIG_CONT, 30, "timed_cont2", at);
        check("timed_cont2_at", at, k + 25);
        wait_rise(0, SIG_CONT, 30, "timed_cont3", at);
        check("timed_cont3_at", at, k + 36);
        wait_rise(0, SIG_DONE, 30, "timed_done", at);
        check("timed_done_at", at, k + 47);
        check("timed_steps", int'(steps_o[0]), 3);

        // Pause-gated Continue: cpu_paused raised 30 cycles after each gap ends.
        pulse_start(1, 0, 2, 4, k);
        while (cyc < k + 36) @(negedge clk);
        paused_s[1] = 1'b1;
        wait_rise(1, SIG_CONT, 10, "wp_cont1", at);
        check("wp_cont1_at", at, k + 37);
        paused_s[1] = 1'b0;
        k2 = at;
        while (cyc < k2 + 35) @(negedge clk);
        paused_s[1] = 1'b1;
        wait_rise(1, SIG_CONT, 10, "wp_cont2", at);
        check("wp_cont2_at", at, k2 + 36);
        paused_s[1] = 1'b0;
        k2 = at;
        wait_rise(1, SIG_DONE, 20, "wp_done", at);
        check("wp_done_at", at, k2 + 5);
        check("wp_steps", int'(steps_o[1]), 2);

        // Abort in the second gap, then a fresh one-step run with gap=0 clamped to 1.
        pulse_start(0, 1, 5, 6, k);
        wait_rise(0, SIG_CONT, 30, "abort_cont1", at);
        wait_rise(0, SIG_CONT, 30, "abort_cont2", at);
        check("abort_cont2_at", at, k + 16);
        repeat (3) @(negedge clk);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        check("abort_busy", int'(busy_o[0]), 0);
        check("abort_done", int'(done_o[0]), 0);
        check("abort_steps", int'(steps_o[0]), 2);
        pulse_start(0, 0, 1, 0, k);
        wait_rise(0, SIG_DONE, 20, "restart_done", at);
        check("restart_done_at", at, k + 5);
        check("restart_steps", int'(steps_o[0]), 1);

        // Async reset in the middle of a Continue pulse.
        pulse_start(0, 3, 2, 5, k);
        wait_rise(0, SIG_CONT, 30, "rst_cont", at);
        check("rst_cont_at", at, k + 10);
        #2 Reset = 1'b1;
        #1;
        check("rst_cont_drop", int'(cont_o[0]), 0);
        check("rst_busy_drop", int'(busy_o[0]), 0);
        check("rst_steps_clr", int'(steps_o[0]), 0);
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        check("rst_idle_busy", int'(busy_o[0]), 0);

        // A start while busy must not disturb the latched parameters.
        pulse_start(0, 3, 2, 5, k);
        repeat (2) @(negedge clk);
        dly_s[0] = '0; cnt_s[0] = CNT_W'(7); gap_s[0] = CNT_W'(1); start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_rise(0, SIG_DONE, 40, "busy_start_done", at);
        check("busy_start_done_at", at, k + 22);
        check("busy_start_steps", int'(steps_o[0]), 2);

        // ARM with cpu_paused stuck low.
        pulse_start(1, 0, 1, 2, k);
`ifdef STEP_SEQ_TIMEOUT_EN
        wait_rise(1, SIG_TMO, 1100, "wd_timeout", at);
        check("wd_timeout_at", at, k + 1028);
        check("wd_done", int'(done_o[1]), 1);
        check("wd_busy", int'(busy_o[1]), 0);
`else
        repeat (1100) @(negedge clk);
        check("wd_busy_stuck", int'(busy_o[1]), 1);
        check("wd_no_timeout", int'(tmo_o[1]), 0);
        abort_s[1] = 1'b1;
        @(negedge clk);
        abort_s[1] = 1'b0;
        check("wd_abort_busy", int'(busy_o[1]), 0);
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
